// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - fixed-priority event sound sequencer sharing one tone generator
module sound_scheduler #(
  parameter int SHORT_CYCLES = 5000000,
  parameter int LONG_CYCLES  = 25000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [3:0] tone,
  output logic       enable,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       seq_done
);

  localparam int CW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  typedef struct packed {
    logic       isNote;
    logic       isLong;
    logic [3:0] tone;
  } step_t;

  state_t        state, nState;
  logic [1:0]    curId, nId;
  logic [2:0]    step, nStep;
  logic [CW-1:0] cnt, nCnt;
  logic [3:0]    pending, nPend;
  logic [3:0]    merged;
  logic [1:0]    top;
  step_t         nInfo;

  function automatic step_t stepInfo(input logic [1:0] id, input logic [2:0] s);
    step_t r;
    case ({id, s})
      5'b00_000, 5'b00_001: r = '{isNote: 1'b1, isLong: 1'b0, tone: 4'd5};
      5'b01_000, 5'b01_001: r = '{isNote: 1'b1, isLong: 1'b0, tone: 4'd0};
      5'b10_000:            r = '{isNote: 1'b0, isLong: 1'b0, tone: 4'd0};
      5'b10_001:            r = '{isNote: 1'b1, isLong: 1'b0, tone: 4'd0};
      5'b10_010:            r = '{isNote: 1'b1, isLong: 1'b0, tone: 4'd1};
      5'b10_011:            r = '{isNote: 1'b1, isLong: 1'b0, tone: 4'd2};
      5'b10_100:            r = '{isNote: 1'b1, isLong: 1'b1, tone: 4'd3};
      5'b11_000, 5'b11_010: r = '{isNote: 1'b1, isLong: 1'b0, tone: 4'd5};
      5'b11_001, 5'b11_011: r = '{isNote: 1'b0, isLong: 1'b0, tone: 4'd0};
      5'b11_100:            r = '{isNote: 1'b1, isLong: 1'b1, tone: 4'd11};
      default:              r = '{isNote: 1'b0, isLong: 1'b0, tone: 4'd0};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] lastStep(input logic [1:0] id);
    return (id >= 2'd2) ? 3'd4 : 3'd1;
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [CW-1:0] loadFor(input logic [1:0] id, input logic [2:0] s);
    step_t i;
    i = stepInfo(id, s);
    return i.isLong ? LONG_LOAD : SHORT_LOAD;
  endfunction

  always_comb begin
    nState = state;
    nId    = curId;
    nStep  = step;
    nCnt   = cnt;
    nPend  = pending;
    merged = '0;
    top    = '0;
    case (state)
      IDLE: begin
        merged = req | pending;
        if (merged != 4'd0) begin
          top    = highest(merged);
          nState = PLAY;
          nId    = top;
          nStep  = 3'd0;
          nCnt   = loadFor(top, 3'd0);
          nPend  = merged & ~(4'b0001 << top);
        end
      end
      PLAY: begin
        // An equal or higher request preempts; the preempted sequence is dropped
        if (req != 4'd0 && highest(req) >= curId) begin
          top   = highest(req);
          nId   = top;
          nStep = 3'd0;
          nCnt  = loadFor(top, 3'd0);
          nPend = (pending | req) & ~(4'b0001 << top);
        end else begin
          merged = pending | req;
          nPend  = merged;
          if (cnt != '0) begin
            nCnt = cnt - CW'(1);
          end else if (step != lastStep(curId)) begin
            nStep = step + 3'd1;
            nCnt  = loadFor(curId, step + 3'd1);
          end else if (curId == 2'd3) begin
            nState = DONE;
            nPend  = '0;
          end else if (merged != 4'd0) begin
            top   = highest(merged);
            nId   = top;
            nStep = 3'd0;
            nCnt  = loadFor(top, 3'd0);
            nPend = merged & ~(4'b0001 << top);
          end else begin
            nState = IDLE;
            nId    = 2'd0;
            nStep  = 3'd0;
          end
        end
      end
      DONE: begin
        nPend = '0;
      end
      default: begin
        nState = IDLE;
      end
    endcase
  end

  always_comb nInfo = stepInfo(nId, nStep);

  // Outputs are registered from next-state values so they line up with the step being entered
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      curId     <= '0;
      step      <= '0;
      cnt       <= '0;
      pending   <= '0;
      tone      <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      active_id <= '0;
      seq_done  <= 1'b0;
    end else begin
      state     <= nState;
      curId     <= nId;
      step      <= nStep;
      cnt       <= nCnt;
      pending   <= nPend;
      tone      <= (nState == PLAY && nInfo.isNote) ? nInfo.tone : 4'd0;
      enable    <= (nState == PLAY) && nInfo.isNote && !mute;
      busy      <= (nState == PLAY);
      active_id <= (nState == PLAY) ? nId : 2'd0;
      seq_done  <= (nState == PLAY) && (nCnt == '0) && (nStep == lastStep(nId));
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - randomized and directed bench for sound_scheduler against a frame-list model
module tb_sound_scheduler;
  localparam int SC = 4;
  localparam int LC = 10;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] req = '0;
  logic       mute = 1'b0;
  logic [3:0] tone;
  logic       enable;
  logic       busy;
  logic [1:0] active_id;
  logic       seq_done;

  always #5 clk = ~clk;

  sound_scheduler #(.SHORT_CYCLES(SC), .LONG_CYCLES(LC)) dut (
    .clk(clk), .resetN(resetN), .req(req), .mute(mute),
    .tone(tone), .enable(enable), .busy(busy), .active_id(active_id), .seq_done(seq_done)
  );

  int nChecks = 0;
  int nPass = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Sequence tables: steps per id, note flag, tone, long flag
  int nSteps[4] = '{2, 2, 5, 5};
  int tTone[4][5] = '{'{5, 5, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 1, 2, 3}, '{5, 0, 5, 0, 11}};
  bit tNote[4][5] = '{'{1, 1, 0, 0, 0}, '{1, 1, 0, 0, 0}, '{0, 1, 1, 1, 1}, '{1, 0, 1, 0, 1}};
  bit tLong[4][5] = '{'{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 1}};

  logic [4:0] q[$];
  int         mId = 0;
  bit         mPlaying = 0;
  bit         mDone = 0;
  logic [3:0] mPend = '0;
  logic       mMute = 1'b0;
  logic       curMute = 1'b0;

  function automatic int hiBit(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic mStart(input int id);
    q.delete();
    for (int s = 0; s < nSteps[id]; s++)
      for (int c = 0; c < (tLong[id][s] ? LC : SC); c++)
        q.push_back({tNote[id][s] ? 1'b1 : 1'b0, 4'(tTone[id][s])});
    mId = id;
    mPlaying = 1;
  endtask

  task automatic mEdge(input logic [3:0] r, input logic m);
    int h;
    logic [3:0] mm;
    mMute = m;
    if (mDone) return;
    if (mPlaying) begin
      if (r != 0 && hiBit(r) >= mId) begin
        h = hiBit(r);
        mPend = (mPend | r) & ~(4'b0001 << h);
        mStart(h);
      end else begin
        mPend = mPend | r;
        void'(q.pop_front());
        if (q.size() == 0) begin
          mPlaying = 0;
          if (mId == 3) begin
            mDone = 1;
            mPend = '0;
          end else if (mPend != 0) begin
            h = hiBit(mPend);
            mPend = mPend & ~(4'b0001 << h);
            mStart(h);
          end
        end
      end
    end else begin
      mm = r | mPend;
      if (mm != 0) begin
        h = hiBit(mm);
        mPend = mm & ~(4'b0001 << h);
        mStart(h);
      end
    end
  endtask

  function automatic logic [8:0] expOut();
    logic [4:0] f;
    if (!mPlaying) return '0;
    f = q[0];
    return {f[3:0], f[4] & ~mMute, 1'b1, 2'(mId), q.size() == 1};
  endfunction

  function automatic logic [8:0] actOut();
    return {tone, enable, busy, active_id, seq_done};
  endfunction

  task automatic cycle(input logic [3:0] r, input string tag);
    req = r;
    mute = curMute;
    @(posedge clk);
    mEdge(r, curMute);
    @(negedge clk);
    req = '0;
    checkVal(tag, 32'(actOut()), 32'(expOut()));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(4'd0, tag);
  endtask

  task automatic asyncReset();
    #2 resetN = 1'b0;
    #1 checkVal("async_reset", 32'(actOut()), 32'd0);
    mPlaying = 0;
    mDone = 0;
    mPend = '0;
    q.delete();
    @(negedge clk);
    checkVal("reset_hold", 32'(actOut()), 32'd0);
    resetN = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    @(negedge clk);
    @(negedge clk);
    checkVal("reset_state", 32'(actOut()), 32'd0);
    resetN = 1'b1;

    idle(9, "pre");
    cycle(4'b0001, "obst_start");
    idle(12, "obst_play");

    cycle(4'b0100, "go_start");
    idle(30, "go_play");

    cycle(4'b0001, "abort_a");
    idle(1, "abort_b");
    cycle(4'b0010, "abort_hi");
    checkVal("abort_tone_id", 32'({tone, active_id}), 32'({4'd0, 2'd1}));
    idle(12, "abort_rest");

    cycle(4'b0010, "queue_a");
    idle(1, "queue_b");
    cycle(4'b0001, "queue_lo");
    idle(20, "queue_rest");

    cycle(4'b0101, "multi");
    idle(30, "multi_rest");

    cycle(4'b1000, "win_start");
    idle(28, "win_play");
    cycle(4'b0001, "done_req");
    idle(3, "done_idle");
    checkVal("done_ignores", 32'(busy), 32'd0);
    asyncReset();
    cycle(4'b0001, "after_reset");
    idle(10, "after_reset_play");

    curMute = 1'b1;
    idle(1, "mute_pre");
    cycle(4'b0001, "mute_start");
    idle(9, "mute_play");
    curMute = 1'b0;
    idle(1, "unmute");
    cycle(4'b0001, "rst_mid_start");
    idle(2, "rst_mid_play");
    asyncReset();
    idle(5, "rst_mid_after");

    for (int i = 0; i < 3000; i++) begin
      if ((mDone && $urandom_range(0, 7) == 0) || $urandom_range(0, 599) == 0) asyncReset();
      if (!mPlaying && $urandom_range(0, 7) == 0) curMute = ~curMute;
      r = '0;
      if ($urandom_range(0, 9) == 0) begin
        r = 4'($urandom_range(1, 15));
        if (r[3] && $urandom_range(0, 5) != 0) r[3] = 1'b0;
      end
      cycle(r, "rand");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
